// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch run controller.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    SW_IDLE  = 2'd0,
    SW_RUN1  = 2'd1,
    SW_RUN10 = 2'd2,
    SW_PAUSE = 2'd3
  } sw_state_t;

  // Bit positions of the buttons in the internal button vector
  localparam int BTN_START1  = 0;
  localparam int BTN_START10 = 1;
  localparam int BTN_PAUSE   = 2;
  localparam int BTN_CLR     = 3;
  localparam int BTN_COUNT   = 4;

  localparam int SW_TICK_DIV_DEFAULT  = 100;
  localparam int SW_FAST_MULT_DEFAULT = 10;

endpackage

// File: rtl/stopwatch_run_ctrl_if.sv
// Button inputs and counter-control outputs of the stopwatch run controller.
interface stopwatch_run_ctrl_if;
  logic       btn_start1;
  logic       btn_start10;
  logic       btn_pause;
  logic       btn_clr;
  logic       count_en;
  logic       count_clr;
  logic [1:0] mode;
  logic       running;

  modport master (
    output btn_start1, btn_start10, btn_pause, btn_clr,
    input  count_en, count_clr, mode, running
  );

  modport slave (
    input  btn_start1, btn_start10, btn_pause, btn_clr,
    output count_en, count_clr, mode, running
  );
endinterface

// File: rtl/stopwatch_prescaler.sv
// Rate prescaler: counts 0..term while incrementing, reports the wrap combinationally.
module stopwatch_prescaler #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         inc,
  input  logic         hold,
  input  logic         zero,
  input  logic [W-1:0] term,
  output logic         wrap,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_reg;
  logic [W-1:0] cnt_next;

  assign wrap = inc & ~hold & ~zero & (cnt_reg == term);
  assign cnt  = cnt_reg;

  always_comb begin
    cnt_next = cnt_reg;
    if (zero) begin
      cnt_next = '0;
    end else if (hold) begin
      cnt_next = cnt_reg;
    end else if (inc) begin
      cnt_next = wrap ? '0 : cnt_reg + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/stopwatch_run_ctrl.sv
// Stopwatch sequencer: button edge detect, run/pause FSM, rate prescaler and
// single-cycle count_en / count_clr strobes for the BCD counter.
module stopwatch_run_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV  = SW_TICK_DIV_DEFAULT,
  parameter int FAST_MULT = SW_FAST_MULT_DEFAULT,
  localparam int PRE_W    = $clog2(TICK_DIV)
) (
  input  logic                 clk,
  input  logic                 n_rst,
  stopwatch_run_ctrl_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = SW_IDLE;
  localparam logic [1:0] ST_RUN1  = SW_RUN1;
  localparam logic [1:0] ST_RUN10 = SW_RUN10;
  localparam logic [1:0] ST_PAUSE = SW_PAUSE;

  localparam logic [PRE_W-1:0] TERM_1X  = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0] TERM_10X = PRE_W'(TICK_DIV / FAST_MULT - 1);

  logic [BTN_COUNT-1:0] btn;
  logic [BTN_COUNT-1:0] btn_prev_reg;
  logic [BTN_COUNT-1:0] btn_evt;
  logic                 win_clr, win_pause, win_start10, win_start1;

  logic [1:0]       state_reg, state_next;
  logic             count_en_reg, count_clr_reg, count_clr_next;
  logic             run_next, mode_switch, resume_over;
  logic             pre_inc, pre_hold, pre_zero, pre_wrap;
  logic [PRE_W-1:0] pre_term, pre_cnt;

  assign btn = {bus.btn_clr, bus.btn_pause, bus.btn_start10, bus.btn_start1};

  generate
    for (genvar gi = 0; gi < BTN_COUNT; gi++) begin : g_edge
      assign btn_evt[gi] = btn[gi] & ~btn_prev_reg[gi];
    end
  endgenerate

  // Only the highest-priority event of a cycle is acted on
  assign win_clr     = btn_evt[BTN_CLR];
  assign win_pause   = btn_evt[BTN_PAUSE] & ~win_clr;
  assign win_start10 = btn_evt[BTN_START10] & ~btn_evt[BTN_PAUSE] & ~win_clr;
  assign win_start1  = btn_evt[BTN_START1] & ~btn_evt[BTN_START10] &
                       ~btn_evt[BTN_PAUSE] & ~win_clr;

  always_comb begin
    state_next     = state_reg;
    count_clr_next = win_clr;
    case (state_reg)
      ST_IDLE: begin
        if (win_start10)     state_next = ST_RUN10;
        else if (win_start1) state_next = ST_RUN1;
      end
      ST_RUN1: begin
        if (win_clr)          state_next = ST_IDLE;
        else if (win_pause)   state_next = ST_PAUSE;
        else if (win_start10) state_next = ST_RUN10;
      end
      ST_RUN10: begin
        if (win_clr)         state_next = ST_IDLE;
        else if (win_pause)  state_next = ST_PAUSE;
        else if (win_start1) state_next = ST_RUN1;
      end
      ST_PAUSE: begin
        if (win_clr)          state_next = ST_IDLE;
        else if (win_start10) state_next = ST_RUN10;
        else if (win_start1)  state_next = ST_RUN1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The prescaler follows the state being entered, so a resume edge already counts
  assign run_next    = (state_next == ST_RUN1) || (state_next == ST_RUN10);
  assign pre_term    = (state_next == ST_RUN10) ? TERM_10X : TERM_1X;
  assign mode_switch = ((state_reg == ST_RUN1) && (state_next == ST_RUN10)) ||
                       ((state_reg == ST_RUN10) && (state_next == ST_RUN1));
  assign resume_over = (state_reg == ST_PAUSE) && run_next && (pre_cnt >= pre_term);
  assign pre_zero    = (state_next == ST_IDLE) || mode_switch || resume_over;
  assign pre_hold    = (state_next == ST_PAUSE);
  assign pre_inc     = run_next;

  stopwatch_prescaler #(
    .W (PRE_W)
  ) u_prescaler (
    .clk   (clk),
    .n_rst (n_rst),
    .inc   (pre_inc),
    .hold  (pre_hold),
    .zero  (pre_zero),
    .term  (pre_term),
    .wrap  (pre_wrap),
    .cnt   (pre_cnt)
  );

  // History resets to all-ones so a button held through reset does not fire
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      btn_prev_reg  <= '1;
      state_reg     <= ST_IDLE;
      count_en_reg  <= 1'b0;
      count_clr_reg <= 1'b0;
    end else begin
      btn_prev_reg  <= btn;
      state_reg     <= state_next;
      count_en_reg  <= pre_wrap;
      count_clr_reg <= count_clr_next;
    end
  end

  assign bus.count_en  = count_en_reg;
  assign bus.count_clr = count_clr_reg;
  assign bus.mode      = state_reg;
  assign bus.running   = (state_reg == ST_RUN1) || (state_reg == ST_RUN10);

endmodule
